// File: rtl/program_counter_pkg.sv
// Core-wide address constants and types shared by fetch, branch and exception logic.
package program_counter_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/program_counter.sv
// Architectural PC register: loads next_pc each rising edge unless stalled by no_update.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int              PC_W     = XLEN,
    parameter logic [PC_W-1:0] PC_RESET = RESET_VECTOR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] next_pc,
    input  logic            no_update,
    output logic [PC_W-1:0] instr_addr
);

    logic [PC_W-1:0] pc_q;

    // Stored verbatim: alignment traps and wrap-around belong to the caller.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= PC_RESET;
        end else if (!no_update) begin
            pc_q <= next_pc;
        end
    end

    assign instr_addr = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed sequence plus randomized stalls, loads and async resets.
module tb_program_counter;
    import program_counter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] next_pc = 32'h0;
    logic        no_update = 1'b0;
    logic [31:0] instr_addr;

    logic [31:0] model_pc = 32'h0;
    bit          chk_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    program_counter dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .no_update  (no_update),
        .instr_addr (instr_addr)
    );

    always #5 clk = ~clk;

    // Model: the architectural PC is whatever was loaded at the last un-stalled edge,
    // or the reset vector after any reset assertion.
    task automatic cycle();
        logic        s_rst;
        logic        s_nu;
        logic [31:0] s_np;
        @(posedge clk);
        s_rst = reset;
        s_nu  = no_update;
        s_np  = next_pc;
        #1;
        if (!s_rst)
            model_pc = RESET_VECTOR;
        else if (!s_nu)
            model_pc = s_np;
    endtask

    task automatic check(input string name, input logic [31:0] want);
        total++;
        if (instr_addr !== want) begin
            bad++;
            $display("FAIL %s: instr_addr=%h expected=%h at t=%0t", name, instr_addr, want, $time);
        end
    endtask

    // Continuous comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (instr_addr !== model_pc) begin
                bad++;
                $display("FAIL model_cmp: instr_addr=%h expected=%h at t=%0t",
                         instr_addr, model_pc, $time);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, instr_addr=%h expected=%h",
                 instr_addr, model_pc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_sum;

        // Reset held for two periods with a pending load.
        reset     = 1'b0;
        next_pc   = 32'h0000_0010;
        no_update = 1'b0;
        model_pc  = RESET_VECTOR;
        #1;
        chk_en = 1'b1;
        check("rst_initial", 32'h0);
        cycle();
        cycle();
        check("rst_hold", 32'h0);

        // Release between edges: nothing moves without a rising edge.
        #2;
        reset = 1'b1;
        #1;
        check("rst_release", 32'h0);

        next_pc   = 32'h4;
        no_update = 1'b0;
        @(negedge clk);
        #1;
        check("load4_pre_edge", 32'h0);
        cycle();
        check("load4", 32'h4);

        // Stall.
        no_update = 1'b1;
        next_pc   = 32'h8;
        @(negedge clk);
        #1;
        check("stall_negedge", 32'h4);
        cycle();
        check("stall_edge1", 32'h4);
        cycle();
        cycle();
        check("stall_edge3", 32'h4);

        no_update = 1'b0;
        cycle();
        check("unstall8", 32'h8);
        next_pc = 32'h8000_0000;
        cycle();
        check("jump", 32'h8000_0000);

        // Asynchronous reset mid-cycle while stalled.
        no_update = 1'b1;
        #2;
        reset    = 1'b0;
        model_pc = RESET_VECTOR;
        #1;
        check("async_rst", 32'h0);
        cycle();
        check("async_rst_held", 32'h0);
        #2;
        reset = 1'b1;

        // Misaligned and wrapped values load verbatim.
        no_update = 1'b0;
        next_pc   = 32'h0000_0006;
        cycle();
        check("misaligned6", 32'h6);
        next_pc = 32'h0000_0000;
        cycle();
        check("zero_after6", 32'h0);
        next_pc = 32'hFFFF_FFFC;
        cycle();
        check("top_word", 32'hFFFF_FFFC);
        wrap_sum = 32'hFFFF_FFFC + 32'h4;
        next_pc  = wrap_sum;
        cycle();
        check("wrap_zero", 32'h0);
        next_pc = 32'h0000_0003;
        cycle();
        check("misaligned3", 32'h3);

        // Randomized phase: junk between edges, stalls, loads and async reset pulses.
        for (int i = 0; i < 3000; i++) begin
            next_pc   = $urandom;
            no_update = $urandom_range(0, 1);
            #2;
            if (reset && ($urandom_range(0, 39) == 0)) begin
                reset    = 1'b0;
                model_pc = RESET_VECTOR;
                #1;
                check("rand_async_rst", RESET_VECTOR);
                #2;
            end else begin
                if (!reset && ($urandom_range(0, 2) == 0))
                    reset = 1'b1;
                #3;
            end
            next_pc   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            no_update = ($urandom_range(0, 2) == 0);
            cycle();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Architectural program-counter register for the single-cycle RISC-V style core.
- Holds the address of the instruction currently being fetched and drives it to instruction memory.
- Loads the next-PC value computed by the datapath (PC+4, branch or jump target) once per clock.
- A stall input (no_update) freezes the current value.

Parameters:
- XLEN, 32, width of the address path (next_pc, instr_addr).
- RESET_VECTOR, 32'h0000_0000, value of instr_addr while reset is asserted and after it is released.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- next_pc  input  XLEN  address to load on the next rising edge when updates are enabled.
- no_update  input  1  1 = hold the current PC (stall); 0 = load next_pc.
- instr_addr  output  XLEN  current PC, driven directly from the register (no combinational path from inputs).

Behaviour:
- Single XLEN-bit register pc_q; instr_addr = pc_q at all times.
- Reset is asynchronous and active-low. When reset goes 0, pc_q becomes RESET_VECTOR immediately, independent of clk. It stays there while reset=0, ignoring next_pc and no_update.
- Reset release: no clock is required. The first rising edge with reset=1 performs a normal update or hold.
- Rising edge of clk with reset=1:
  - no_update=0: pc_q <= next_pc.
  - no_update=1: pc_q <= pc_q.
- Falling edge: no effect. instr_addr must not change on a negative edge.
- Latency: next_pc appears on instr_addr exactly one rising edge after it is sampled. No combinational feed-through from next_pc to instr_addr.
- Width/arithmetic: no increment inside the block; next_pc is loaded verbatim, all XLEN bits.
  - No alignment masking. Misaligned values (low bits != 00) are stored as-is; trapping is the decode/exception logic's job.
  - Wrap-around is the caller's concern; 32'hFFFF_FFFC + 4 = 0 computed externally loads as 0.
- no_update and next_pc are sampled only at the rising edge. Changes between edges have no effect.
- Reset asserted mid-stall or mid-update: reset wins; pc_q = RESET_VECTOR regardless of no_update.
- X on next_pc while no_update=1 must not corrupt pc_q.

Decomposition:
- Shared core package: XLEN and RESET_VECTOR constants (reused by fetch, branch unit, exception logic), plus an addr_t typedef of XLEN bits.
- No sub-module; the block is a single enable-gated register.

Test Plan:
- Hold reset=0 for two clk periods with next_pc=32'h0000_0010, no_update=0 -> instr_addr = 0 throughout. Release reset=1 with no clock edge -> instr_addr still 0.
- reset=1, no_update=0, next_pc=4 -> instr_addr stays 0 after the falling edge, becomes 4 after the next rising edge.
- From 4: no_update=1, next_pc=8 -> instr_addr stays 4 across the falling edge and the rising edge, and across two further cycles.
- Drop no_update to 0 with next_pc=8 -> instr_addr = 8 after one rising edge. Then next_pc=32'h8000_0000 (jump) -> 32'h8000_0000 after the next rising edge.
- With instr_addr=32'h8000_0000, pull reset=0 between clock edges -> instr_addr = 0 immediately (before any edge), even with no_update=1.
- Misaligned/wrap values: next_pc=32'h0000_0006 then 32'h0000_0000 with no_update=0 -> instr_addr follows exactly (6, then 0) one rising edge later each; no masking.
